// File: rtl/stage_memory_pkg.sv
// stage_memory_pkg
// Shared encodings and helpers for the memory stage:
//   kind_e         - operation class carried on in_kind
//   size_e         - access size carried on in_size
//   is_misaligned  - natural-alignment test for an access
//   load_extract   - lane select plus sign/zero extension of a load response
// The helpers work on a 64-bit container. 32-bit callers zero-extend their
// inputs and truncate the result.
package stage_memory_pkg;

  typedef enum logic [1:0] {
    KIND_ALU   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_RSVD  = 2'd3   // behaves as ALU
  } kind_e;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } size_e;

  // Width of the stored address offset: enough to select a byte in a double.
  localparam int OFF_W = 3;

  function automatic logic is_misaligned(input size_e size, input logic [2:0] addr,
                                         input logic xlen64);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr[0];
      SIZE_WORD: bad = |addr[1:0];
      default:   bad = (|addr) | ~xlen64;  // a double does not exist on a 32-bit datapath
    endcase
    return bad;
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] data, input size_e size,
                                               input logic sgn, input logic [2:0] off,
                                               input logic xlen64);
    logic [2:0]  lane_off;
    logic [63:0] shifted;
    logic [63:0] res;
    // Clear the offset bits below the access size, so the byte offset of the
    // lane is exactly the shift amount.
    lane_off = off;
    case (size)
      SIZE_BYTE: lane_off = off;
      SIZE_HALF: lane_off = {off[2:1], 1'b0};
      SIZE_WORD: lane_off = {off[2], 2'b00};
      default:   lane_off = 3'b000;
    endcase
    // On a 32-bit datapath the whole response is one word, so bit 2 means nothing.
    if (!xlen64) lane_off[2] = 1'b0;
    shifted = data >> {lane_off, 3'b000};
    case (size)
      SIZE_BYTE: res = {{56{sgn & shifted[7]}},  shifted[7:0]};
      SIZE_HALF: res = {{48{sgn & shifted[15]}}, shifted[15:0]};
      SIZE_WORD: res = {{32{sgn & shifted[31]}}, shifted[31:0]};
      default:   res = shifted;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_track_fifo.sv
// load_track_fifo
// Small synchronous FIFO that records the metadata of outstanding loads in
// issue order. A push while full and a pop while empty are both ignored.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data       - write an entry at the tail
//   pop                   - drop the head entry
//   pop_data              - current head entry (valid when !empty)
//   full, empty           - occupancy flags
module load_track_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH. The explicit compare keeps DEPTH=1 pinned at 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;  // idle, or push and pop together
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stage_memory_pipe.sv
// stage_memory_pipe
// Memory stage of an in-order pipeline. ALU results go straight to
// writeback. Loads and stores issue a memory request. Each accepted load is
// tracked in a FIFO so that its in-order response can be lane-selected,
// extended and written back.
//
// Handshakes: each interface uses valid/ready. A beat moves on a cycle where
// both are high, and a source holds its payload stable until it moves.
// in_ready depends only on in_kind/in_size/in_value, mem_req_ready and FIFO
// state, never on mem_resp_*. The response channel has no ready; a beat is
// consumed the cycle it is valid.
//
// Ports:
//   clk, rst                             - clock, asynchronous active-high reset
//   in_valid/in_ready                    - upstream handshake
//   in_kind, in_dest, in_value, in_wdata,
//   in_size, in_signed                   - operation from the previous stage
//   mem_req_*                            - request to memory (addr/wdata/size pass through)
//   mem_resp_valid, mem_resp_data        - in-order load responses
//   wb_valid, wb_addr, wb_value          - registered register-file writeback
//   err_misaligned                       - one-cycle pulse after a misaligned access is accepted
//   err_unexpected                       - sticky: a response arrived with no load outstanding
module stage_memory_pipe
  import stage_memory_pkg::*;
#(
  parameter int XLEN    = 32,  // 32 or 64
  parameter int RADDR_W = 4,
  parameter int DEPTH   = 2    // power of two, >= 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_kind,
  input  logic [RADDR_W-1:0] in_dest,
  input  logic [XLEN-1:0]    in_value,
  input  logic [XLEN-1:0]    in_wdata,
  input  logic [1:0]         in_size,
  input  logic               in_signed,
  output logic               mem_req_valid,
  output logic               mem_req_we,
  output logic [XLEN-1:0]    mem_req_addr,
  output logic [XLEN-1:0]    mem_req_wdata,
  output logic [1:0]         mem_req_size,
  input  logic               mem_req_ready,
  input  logic               mem_resp_valid,
  input  logic [XLEN-1:0]    mem_resp_data,
  output logic               wb_valid,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]    wb_value,
  output logic               err_misaligned,
  output logic               err_unexpected
);

  localparam logic XLEN64  = (XLEN == 64);
  localparam int   ENTRY_W = RADDR_W + 3 + OFF_W;  // dest, size, signed, offset

  kind_e              kind;
  logic               is_load;
  logic               is_store;
  logic               misaligned;
  logic               transfer;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  logic [RADDR_W-1:0] head_dest;
  logic [1:0]         head_size;
  logic               head_signed;
  logic [OFF_W-1:0]   head_off;
  logic [63:0]        resp64;
  logic [63:0]        load_ext;

  assign kind       = kind_e'(in_kind);
  assign is_load    = (kind == KIND_LOAD);
  assign is_store   = (kind == KIND_STORE);
  assign misaligned = (is_load | is_store)
                    & is_misaligned(size_e'(in_size), in_value[2:0], XLEN64);

  assign mem_req_we    = is_store;
  assign mem_req_addr  = in_value;
  assign mem_req_wdata = in_wdata;
  assign mem_req_size  = in_size;

  // A misaligned access is taken and dropped right away, so it never stalls.
  // ALU results wait for outstanding loads, which keeps writebacks in order
  // and at most one per cycle.
  always_comb begin
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    if (misaligned) begin
      in_ready = 1'b1;
    end else if (is_load) begin
      in_ready      = mem_req_ready & ~full;
      mem_req_valid = in_valid & ~full;
    end else if (is_store) begin
      in_ready      = mem_req_ready;
      mem_req_valid = in_valid;
    end else begin
      in_ready = empty;
    end
  end

  assign transfer   = in_valid & in_ready;
  assign push       = transfer & is_load & ~misaligned;
  assign pop        = mem_resp_valid & ~empty;
  assign push_entry = {in_dest, in_size, in_signed, in_value[OFF_W-1:0]};

  load_track_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_track (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty)
  );

  assign head_dest   = head[ENTRY_W-1 -: RADDR_W];
  assign head_size   = head[OFF_W+2 -: 2];
  assign head_signed = head[OFF_W];
  assign head_off    = head[OFF_W-1:0];
  assign resp64      = 64'(mem_resp_data);
  assign load_ext    = load_extract(resp64, size_e'(head_size), head_signed, head_off, XLEN64);

  // A load pop needs a non-empty FIFO and an ALU transfer needs an empty one,
  // so at most one writeback source is active in a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid       <= 1'b0;
      wb_addr        <= '0;
      wb_value       <= '0;
      err_misaligned <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      err_misaligned <= transfer & misaligned;
      if (mem_resp_valid & empty) err_unexpected <= 1'b1;
      if (pop) begin
        wb_valid <= (head_dest != '0);
        wb_addr  <= head_dest;
        wb_value <= load_ext[XLEN-1:0];
      end else if (transfer & ~is_load & ~is_store) begin
        wb_valid <= (in_dest != '0);
        wb_addr  <= in_dest;
        wb_value <= in_value;
      end
    end
  end

endmodule

// File: tb/tb_stage_memory_pipe.sv
module tb_stage_memory_pipe;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 4;
  localparam int DEPTH   = 2;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_kind;
  logic [RADDR_W-1:0] in_dest;
  logic [XLEN-1:0]    in_value;
  logic [XLEN-1:0]    in_wdata;
  logic [1:0]         in_size;
  logic               in_signed;
  logic               mem_req_valid;
  logic               mem_req_we;
  logic [XLEN-1:0]    mem_req_addr;
  logic [XLEN-1:0]    mem_req_wdata;
  logic [1:0]         mem_req_size;
  logic               mem_req_ready;
  logic               mem_resp_valid;
  logic [XLEN-1:0]    mem_resp_data;
  logic               wb_valid;
  logic [RADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]    wb_value;
  logic               err_misaligned;
  logic               err_unexpected;

  int checks;
  int failures;

  stage_memory_pipe #(
    .XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_dest(in_dest),
    .in_value(in_value), .in_wdata(in_wdata), .in_size(in_size), .in_signed(in_signed),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_size(mem_req_size), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_value(wb_value),
    .err_misaligned(err_misaligned), .err_unexpected(err_unexpected)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [RADDR_W-1:0] d,
                       input logic [XLEN-1:0] val, input logic [1:0] sz, input logic sg);
    in_valid  = v;
    in_kind   = k;
    in_dest   = d;
    in_value  = val;
    in_size   = sz;
    in_signed = sg;
    #1;
  endtask

  task automatic resp(input logic v, input logic [XLEN-1:0] data);
    mem_resp_valid = v;
    mem_resp_data  = data;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_kind = 2'd0; in_dest = '0; in_value = '0; in_wdata = '0;
    in_size = 2'd0; in_signed = 1'b0; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0;

    // Reset state
    #3;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_addr", 64'(wb_addr), 64'd0);
    chk("rst_wb_value", 64'(wb_value), 64'd0);
    chk("rst_err_mis", 64'(err_misaligned), 64'd0);
    chk("rst_err_unx", 64'(err_unexpected), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // ALU dest=5 value=0x1234
    drive(1, 2'd0, 4'd5, 32'h1234, 2'd2, 0);
    chk("alu_in_ready", 64'(in_ready), 64'd1);
    chk("alu_no_req", 64'(mem_req_valid), 64'd0);
    tick();
    drive(0, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    chk("alu_wb_valid", 64'(wb_valid), 64'd1);
    chk("alu_wb_addr", 64'(wb_addr), 64'd5);
    chk("alu_wb_value", 64'(wb_value), 64'h1234);
    tick();
    chk("alu_wb_pulse", 64'(wb_valid), 64'd0);

    // ALU to x0 and reserved kind: no writeback for dest 0, kind 3 acts as ALU
    drive(1, 2'd3, 4'd0, 32'h99, 2'd0, 0);
    chk("rsvd_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(0, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    chk("alu_x0_no_wb", 64'(wb_valid), 64'd0);

    // Load byte signed at 0x1003, response 0x80FF_FFFF
    drive(1, 2'd1, 4'd7, 32'h1003, 2'd0, 1);
    chk("ldb_req_valid", 64'(mem_req_valid), 64'd1);
    chk("ldb_in_ready", 64'(in_ready), 64'd1);
    chk("ldb_req_we", 64'(mem_req_we), 64'd0);
    chk("ldb_req_addr", 64'(mem_req_addr), 64'h1003);
    chk("ldb_req_size", 64'(mem_req_size), 64'd0);
    tick();
    drive(0, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    resp(1, 32'h80FF_FFFF);
    tick();
    resp(0, 32'h0);
    chk("ldbs_wb_valid", 64'(wb_valid), 64'd1);
    chk("ldbs_wb_addr", 64'(wb_addr), 64'd7);
    chk("ldbs_wb_value", 64'(wb_value), 64'hFFFF_FF80);
    drive(1, 2'd1, 4'd8, 32'h1003, 2'd0, 0);
    tick();
    drive(0, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    resp(1, 32'h80FF_FFFF);
    tick();
    resp(0, 32'h0);
    chk("ldbu_wb_addr", 64'(wb_addr), 64'd8);
    chk("ldbu_wb_value", 64'(wb_value), 64'h0000_0080);

    // Aligned store: waits on mem_req_ready, no writeback, no tracking
    in_wdata = 32'hDEAD_BEEF;
    mem_req_ready = 1'b0;
    drive(1, 2'd2, 4'd3, 32'h100, 2'd2, 0);
    chk("st_req_valid", 64'(mem_req_valid), 64'd1);
    chk("st_in_ready_stall", 64'(in_ready), 64'd0);
    chk("st_req_we", 64'(mem_req_we), 64'd1);
    chk("st_req_wdata", 64'(mem_req_wdata), 64'hDEAD_BEEF);
    mem_req_ready = 1'b1;
    #1;
    chk("st_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    chk("st_no_wb", 64'(wb_valid), 64'd0);
    chk("st_fifo_empty", 64'(in_ready), 64'd1);
    drive(0, 2'd0, 4'd0, 32'h0, 2'd0, 0);

    // DEPTH=2: three back-to-back loads, third stalls until a response
    drive(1, 2'd1, 4'd1, 32'h0, 2'd2, 0);
    tick();
    drive(1, 2'd1, 4'd2, 32'h4, 2'd2, 0);
    chk("ld2_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1, 2'd1, 4'd3, 32'hA, 2'd1, 1);
    chk("ld3_full_ready", 64'(in_ready), 64'd0);
    chk("ld3_full_req", 64'(mem_req_valid), 64'd0);
    resp(1, 32'h1111_2222);
    chk("ld3_pop_ready", 64'(in_ready), 64'd0);
    tick();
    resp(0, 32'h0);
    chk("ld1_wb_addr", 64'(wb_addr), 64'd1);
    chk("ld1_wb_value", 64'(wb_value), 64'h1111_2222);
    chk("ld3_now_ready", 64'(in_ready), 64'd1);
    tick();
    drive(0, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    chk("ld3_no_wb_yet", 64'(wb_valid), 64'd0);
    resp(1, 32'h3333_4444);
    tick();
    chk("ld2_wb_addr", 64'(wb_addr), 64'd2);
    chk("ld2_wb_value", 64'(wb_value), 64'h3333_4444);
    resp(1, 32'hABCD_0000);
    tick();
    resp(0, 32'h0);
    chk("ld3_wb_valid", 64'(wb_valid), 64'd1);
    chk("ld3_wb_addr", 64'(wb_addr), 64'd3);
    chk("ld3_wb_value", 64'(wb_value), 64'hFFFF_ABCD);

    // ALU behind a pending load
    drive(1, 2'd1, 4'd4, 32'h10, 2'd2, 0);
    tick();
    drive(1, 2'd0, 4'd6, 32'h55, 2'd2, 0);
    chk("alu_wait_0", 64'(in_ready), 64'd0);
    tick();
    chk("alu_wait_1", 64'(in_ready), 64'd0);
    resp(1, 32'h77);
    chk("alu_wait_resp", 64'(in_ready), 64'd0);
    tick();
    resp(0, 32'h0);
    chk("ldp_wb_addr", 64'(wb_addr), 64'd4);
    chk("ldp_wb_value", 64'(wb_value), 64'h77);
    chk("alu_released", 64'(in_ready), 64'd1);
    tick();
    drive(0, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    chk("alu_after_wb_valid", 64'(wb_valid), 64'd1);
    chk("alu_after_wb_addr", 64'(wb_addr), 64'd6);
    chk("alu_after_wb_value", 64'(wb_value), 64'h55);

    // Misaligned accesses
    drive(1, 2'd1, 4'd9, 32'h2, 2'd2, 0);
    chk("mis_w_req", 64'(mem_req_valid), 64'd0);
    chk("mis_w_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1, 2'd2, 4'd0, 32'h1, 2'd1, 0);
    chk("mis_w_pulse", 64'(err_misaligned), 64'd1);
    chk("mis_w_no_wb", 64'(wb_valid), 64'd0);
    chk("mis_h_req", 64'(mem_req_valid), 64'd0);
    tick();
    drive(1, 2'd1, 4'd9, 32'h0, 2'd3, 0);
    chk("mis_h_pulse", 64'(err_misaligned), 64'd1);
    chk("mis_d_req", 64'(mem_req_valid), 64'd0);
    tick();
    drive(0, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    chk("mis_d_pulse", 64'(err_misaligned), 64'd1);
    drive(1, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    chk("mis_no_push", 64'(in_ready), 64'd1);
    drive(0, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    tick();
    chk("mis_pulse_end", 64'(err_misaligned), 64'd0);

    // Unexpected response
    resp(1, 32'hCAFE);
    tick();
    resp(0, 32'h0);
    chk("unx_set", 64'(err_unexpected), 64'd1);
    chk("unx_no_wb", 64'(wb_valid), 64'd0);
    tick();
    tick();
    chk("unx_sticky", 64'(err_unexpected), 64'd1);

    // Reset with two loads pending
    drive(1, 2'd1, 4'd10, 32'h20, 2'd2, 0);
    tick();
    drive(1, 2'd1, 4'd11, 32'h24, 2'd2, 0);
    tick();
    drive(1, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_wb_addr", 64'(wb_addr), 64'd0);
    chk("arst_wb_value", 64'(wb_value), 64'd0);
    chk("arst_err_unx", 64'(err_unexpected), 64'd0);
    chk("arst_fifo_empty", 64'(in_ready), 64'd1);
    #1;
    rst = 1'b0;
    drive(0, 2'd0, 4'd0, 32'h0, 2'd0, 0);
    resp(1, 32'h1234);
    tick();
    resp(0, 32'h0);
    chk("post_rst_unx", 64'(err_unexpected), 64'd1);
    chk("post_rst_no_wb", 64'(wb_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
